// File: rtl/mem_stage_cached.sv
// MEM stage: direct-mapped write-through/allocate cache, posted write FIFO, req/ack memory port.
// Latency 1 cycle on hits; read misses and stores into a full FIFO freeze the pipeline.
module mem_stage_cached #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEST_W     = 3,
    parameter int IDX_W      = 6,
    parameter int WBUF_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_mem_wr,
    input  logic              in_mem_rd,
    input  logic              in_wb_en,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              cache_inv,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_mem_rd,
    output logic              out_wb_en,
    output logic [DEST_W-1:0] out_dest,
    output logic [DEST_W-1:0] mem_op_dest,
    output logic              freeze,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state, state_next;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [ADDR_W-1:0] wbuf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              refill;

    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag, fill_tag;
    logic              rd_miss, full, empty, accept, push, pop, fill;
    logic              req_next, we_next;
    logic [ADDR_W-1:0] maddr_next;
    logic [DATA_W-1:0] mwdata_next;

    assign idx      = in_addr[IDX_W-1:0];
    assign tag      = in_addr[ADDR_W-1:IDX_W];
    assign fill_idx = mem_addr[IDX_W-1:0];
    assign fill_tag = mem_addr[ADDR_W-1:IDX_W];

    assign hit         = valid[idx] && (tag_mem[idx] == tag);
    assign rd_miss     = in_mem_rd && !hit;
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign freeze      = rd_miss || (in_mem_wr && full);
    assign accept      = !freeze;
    assign push        = accept && in_mem_wr;
    assign pop         = (state == WRITE) && mem_ack;
    assign fill        = (state == READ) && mem_ack;
    assign mem_op_dest = in_wb_en ? in_dest : '0;

    // Reads wait for an empty FIFO so the SRAM never returns stale data.
    always_comb begin
        state_next  = state;
        req_next    = mem_req;
        we_next     = mem_we;
        maddr_next  = mem_addr;
        mwdata_next = mem_wdata;
        case (state)
            IDLE: begin
                if (rd_miss && empty) begin
                    state_next = READ;
                    req_next   = 1'b1;
                    we_next    = 1'b0;
                    maddr_next = in_addr;
                end else if (!empty) begin
                    state_next  = WRITE;
                    req_next    = 1'b1;
                    we_next     = 1'b1;
                    maddr_next  = wbuf_addr[rd_ptr];
                    mwdata_next = wbuf_data[rd_ptr];
                end
            end
            READ, WRITE: begin
                if (mem_ack) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= maddr_next;
            mem_wdata <= mwdata_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr[wr_ptr] <= in_addr;
            wbuf_data[wr_ptr] <= in_wdata;
        end
    end

    // Tag/data need no reset; the valid bits alone decide a hit.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end
        if (push) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cache_inv) begin
            valid <= '0;
        end else begin
            if (fill) valid[fill_idx] <= 1'b1;
            if (push) valid[idx]      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr   <= '0;
            out_rdata  <= '0;
            out_mem_rd <= 1'b0;
            out_wb_en  <= 1'b0;
            out_dest   <= '0;
        end else if (accept) begin
            if (flush) begin
                out_addr   <= '0;
                out_rdata  <= '0;
                out_mem_rd <= 1'b0;
                out_wb_en  <= 1'b0;
                out_dest   <= '0;
            end else begin
                out_addr   <= in_addr;
                out_rdata  <= in_mem_rd ? data_mem[idx] : '0;
                out_mem_rd <= in_mem_rd;
                out_wb_en  <= in_wb_en;
                out_dest   <= in_dest;
            end
        end
    end

    // The load retiring right after a refill was already counted as a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            refill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (fill) begin
                refill <= 1'b1;
                if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
            end else if (accept && in_mem_rd) begin
                refill <= 1'b0;
                if (!refill && hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_cached.sv
// Randomized scoreboard bench for mem_stage_cached against a program-order memory model.
module tb_mem_stage_cached;
    localparam int DW = 16, AW = 16, DSW = 3, IW = 6, WD = 4, CW = 4;

    logic            clk = 1'b0;
    logic            rst, flush, in_mem_wr, in_mem_rd, in_wb_en, cache_inv;
    logic [AW-1:0]   in_addr, out_addr, mem_addr;
    logic [DW-1:0]   in_wdata, out_rdata, mem_wdata, mem_rdata;
    logic [DSW-1:0]  in_dest, out_dest, mem_op_dest;
    logic            out_mem_rd, out_wb_en, freeze, hit, mem_req, mem_we, mem_ack;
    logic [CW-1:0]   hit_count, miss_count;

    mem_stage_cached #(.DATA_W(DW), .ADDR_W(AW), .DEST_W(DSW), .IDX_W(IW),
                       .WBUF_DEPTH(WD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_mem_wr(in_mem_wr), .in_mem_rd(in_mem_rd), .in_wb_en(in_wb_en), .in_dest(in_dest),
        .cache_inv(cache_inv), .out_addr(out_addr), .out_rdata(out_rdata),
        .out_mem_rd(out_mem_rd), .out_wb_en(out_wb_en), .out_dest(out_dest),
        .mem_op_dest(mem_op_dest), .freeze(freeze), .hit(hit), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] rdata;
        logic        mem_rd;
        logic        wb_en;
        logic [2:0]  dest;
        time         t;
    } exp_t;
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    int          vectors = 0, miscompares = 0;
    exp_t        sbq[$];
    wr_t         wq[$];
    exp_t        last_exp;
    logic [15:0] sram   [65536];
    logic [15:0] shadow [65536];
    logic        res_v [64];
    logic [15:0] res_a [64];
    int          m_hits = 0, m_misses = 0;
    int          fixed_lat = 3, lat = 3;
    bit          hold_ack = 1'b0;
    logic [15:0] cur_load_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        m_hits   = 0;
        m_misses = 0;
        for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_count"},  32'(hit_count),  32'(sat(m_hits)));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(sat(m_misses)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"}, {out_addr, out_rdata}, 32'h0);
        check({tag, "_ctl"}, 32'({out_mem_rd, out_wb_en, out_dest, mem_req, mem_we, freeze}), 32'h0);
        check({tag, "_mem"}, {mem_addr, mem_wdata}, 32'h0);
        check({tag, "_cnt"}, 32'({hit_count, miss_count}), 32'h0);
    endtask

    // Drives one instruction, holds it through any freeze, and records the expected retirement.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input logic wb, input logic [2:0] dst, input logic fl, input logic inv,
                         output int fz);
        exp_t e;
        logic ph;
        int   k;
        in_mem_rd = rd; in_mem_wr = wr; in_addr = a; in_wdata = d;
        in_wb_en = wb; in_dest = dst; flush = fl; cache_inv = inv;
        if (rd) cur_load_addr = a;
        ph = res_v[a[5:0]] && (res_a[a[5:0]] == a);
        fz = 0;
        @(negedge clk);
        check("mem_op_dest", 32'(mem_op_dest), wb ? 32'(dst) : 32'h0);
        if (rd) check("hit", 32'(hit), 32'(ph));
        k = 0;
        while (freeze && k < 300) begin
            fz++;
            k++;
            @(negedge clk);
        end
        if (freeze) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: addr 0x%0h still frozen after %0d cycles", a, k);
        end else begin
            e.addr   = fl ? 16'h0 : a;
            e.rdata  = (fl || !rd) ? 16'h0 : shadow[a];
            e.mem_rd = fl ? 1'b0 : rd;
            e.wb_en  = fl ? 1'b0 : wb;
            e.dest   = fl ? 3'h0 : dst;
            e.t      = $time;
            sbq.push_back(e);
            last_exp = e;
            if (rd) begin
                if (ph) m_hits++; else m_misses++;
                res_v[a[5:0]] = 1'b1;
                res_a[a[5:0]] = a;
            end
            if (wr) begin
                shadow[a] = d;
                res_v[a[5:0]] = 1'b1;
                res_a[a[5:0]] = a;
                wq.push_back('{addr: a, data: d});
            end
            if (inv) for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        in_mem_rd = 1'b0; in_mem_wr = 1'b0; flush = 1'b0; cache_inv = 1'b0;
    endtask

    task automatic drain();
        int k, fz;
        k = 0;
        while ((wq.size() > 0 || mem_req) && k < 100) begin
            issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'h0, 1'b0, 1'b0, fz);
            k++;
        end
        check("drained", 32'(wq.size()), 32'h0);
    endtask

    // Output monitor: pops one expected retirement per cycle once it has been latched.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].t < $time) begin
                e = sbq.pop_front();
                check("out_addr",   32'(out_addr),   32'(e.addr));
                check("out_rdata",  32'(out_rdata),  32'(e.rdata));
                check("out_mem_rd", 32'(out_mem_rd), 32'(e.mem_rd));
                check("out_wb_en",  32'(out_wb_en),  32'(e.wb_en));
                check("out_dest",   32'(out_dest),   32'(e.dest));
            end
        end
    end

    // SRAM responder: acks after lat+1 cycles of request, checks write order and read coherence.
    initial begin
        int  cnt;
        wr_t w;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (mem_req && !hold_ack) begin
                cnt++;
                if (cnt > lat) begin
                    cnt     = 0;
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        if (wq.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", mem_addr, mem_wdata);
                        end else begin
                            w = wq.pop_front();
                            check("wr_addr", 32'(mem_addr),  32'(w.addr));
                            check("wr_data", 32'(mem_wdata), 32'(w.data));
                        end
                        sram[mem_addr] = mem_wdata;
                    end else begin
                        check("drain_before_read", 32'(wq.size()), 32'h0);
                        check("rd_addr", 32'(mem_addr), 32'(cur_load_addr));
                        mem_rdata = sram[mem_addr];
                    end
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        int          fz, k, r;
        logic [15:0] a, d;
        logic        wb;
        logic [2:0]  dst;

        for (int i = 0; i < 65536; i++) begin
            sram[i]   = 16'(i) ^ 16'hA5C3;
            shadow[i] = 16'(i) ^ 16'hA5C3;
        end
        sram[16'h0040]   = 16'hBEEF;
        shadow[16'h0040] = 16'hBEEF;
        model_reset();

        rst = 1'b1; flush = 1'b0; in_mem_wr = 1'b0; in_mem_rd = 1'b0; in_wb_en = 1'b0;
        cache_inv = 1'b0; in_addr = '0; in_wdata = '0; in_dest = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset");

        // Cold miss with a 3-cycle ack delay, then a hit on the same line.
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 3'd5, 1'b0, 1'b0, fz);
        check("miss_freeze_cycles", 32'(fz), 32'd5);
        check_counts("t1");
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0, fz);
        check("hit_freeze_cycles", 32'(fz), 32'd0);
        check_counts("t2");

        // Invalidate, then the same load misses again.
        issue(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, fz);
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 3'd1, 1'b0, 1'b0, fz);
        check("reinv_miss_freeze", 32'(fz > 0), 32'd1);
        check_counts("t5");

        // Four stores fill the FIFO while the first write is held; the fifth freezes.
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, 16'h0100 + 16'(i * 3), 16'hC000 + 16'(i), 1'b0, 3'd0, 1'b0, 1'b0, fz);
            check("store_nofreeze", 32'(fz), 32'd0);
        end
        in_mem_wr = 1'b1; in_addr = 16'h0110; in_wdata = 16'hC0DE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_freeze", 32'(freeze), 32'd1);
            @(posedge clk);
            #1;
        end
        hold_ack  = 1'b0;
        fixed_lat = 1;
        issue(1'b0, 1'b1, 16'h0110, 16'hC0DE, 1'b0, 3'd0, 1'b0, 1'b0, fz);
        drain();

        // Store, evict its line with a load, then reload it from memory after the drain.
        fixed_lat = -1;
        issue(1'b0, 1'b1, 16'h0001, 16'h1234, 1'b0, 3'd0, 1'b0, 1'b0, fz);
        issue(1'b1, 1'b0, 16'h0041, 16'h0, 1'b1, 3'd3, 1'b0, 1'b0, fz);
        issue(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 3'd4, 1'b0, 1'b0, fz);
        check_counts("t4");
        drain();

        // Reset while a read request is outstanding.
        fixed_lat = 3;
        lat       = 3;
        in_mem_rd = 1'b1; in_addr = 16'h0A3F; in_wb_en = 1'b1; in_dest = 3'd7;
        cur_load_addr = 16'h0A3F;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_req && k < 20);
        check("req_before_reset", 32'(mem_req), 32'd1);
        check("freeze_in_read", 32'(freeze), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; in_mem_rd = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        model_reset();

        // Flush with no freeze zeroes the stage; flush while frozen leaves it alone.
        issue(1'b0, 1'b1, 16'h0005, 16'h7777, 1'b1, 3'd1, 1'b0, 1'b0, fz);
        issue(1'b0, 1'b0, 16'h1234, 16'h0, 1'b1, 3'd5, 1'b1, 1'b0, fz);
        issue(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 3'd6, 1'b0, 1'b0, fz);
        in_mem_rd = 1'b1; in_addr = 16'h0A3F; in_wb_en = 1'b1; in_dest = 3'd2; flush = 1'b1;
        cur_load_addr = 16'h0A3F;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("flush_frz_freeze", 32'(freeze), 32'd1);
            check("flush_frz_addr",   32'(out_addr),  32'(last_exp.addr));
            check("flush_frz_rdata",  32'(out_rdata), 32'(last_exp.rdata));
            check("flush_frz_ctl",    32'({out_wb_en, out_dest}), 32'({last_exp.wb_en, last_exp.dest}));
            @(posedge clk);
            #1;
        end
        issue(1'b1, 1'b0, 16'h0A3F, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0, fz);
        check_counts("t6");

        // Random mix over a few lines and tags; counters saturate at 15.
        fixed_lat = -1;
        for (int n = 0; n < 300; n++) begin
            r   = int'($urandom_range(0, 9));
            a   = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            d   = 16'($urandom);
            wb  = 1'($urandom);
            dst = 3'($urandom);
            if (r < 4)
                issue(1'b1, 1'b0, a, 16'h0, wb, dst, 1'b0, 1'b0, fz);
            else if (r < 8)
                issue(1'b0, 1'b1, a, d, wb, dst, 1'b0, 1'b0, fz);
            else
                issue(1'b0, 1'b0, a, 16'h0, wb, dst, ($urandom_range(0, 2) == 0), (r == 9), fz);
        end
        drain();
        check_counts("final");
        issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'h0, 1'b0, 1'b0, fz);
        @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
